serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller: sequences one 1-bit full-adder cell (built from two HalfAdder cells)

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder_cell.sv | 35 +++
 rtl/half_adder.sv | 15 +
 rtl/serial_adder_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e   : controller FSM states, 2-bit encoding IDLE=00, RUN=01, DONE=10
//   MAX_WIDTH : largest supported operand width
package serial_adder_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR gate.
// This is the only combinational datapath of the serial adder.
//   a, b, cin : input bits
//   s         : sum bit
//   co        : carry-out bit
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  // Both half-adder carries can never be high together, so OR is exact.
  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder cell.
//   a, b : input bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: walks one full_adder_cell over WIDTH cycles, LSB first,
// to compute a + b + cin. Start/busy/done handshake; result held until the next done.
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous active-low reset
//   start  : request, honoured only in IDLE or DONE
//   a, b   : operands, captured on the accepted start
//   cin    : carry-in, captured on the accepted start
//   sub    : subtract select (only when SERIAL_ADDER_SUB_EN is defined)
//   busy   : high while in RUN
//   done   : one-cycle pulse, result valid from this cycle on
//   sum    : registered result
//   cout   : registered carry-out of the MSB (with sub: 1 means no borrow)
// Build option: define SERIAL_ADDER_SUB_EN to add the sub port and a - b support.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8  // legal range 1..MAX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] s_sr_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             accept;
  logic             last_bit;
  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  full_adder_cell u_cell (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (cell_s),
    .co  (cell_co)
  );

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at bit 0.
  assign s_next   = WIDTH'({cell_s, s_sr_q} >> 1);

  // Operand conditioning at load time; subtraction is a + ~b + 1.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~b : b;
    carry_load = sub | cin;
`else
    b_load     = b;
    carry_load = cin;
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: shift registers, carry flop, bit counter, result holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_sr_q  <= a;
      b_sr_q  <= b_load;
      s_sr_q  <= '0;
      carry_q <= carry_load;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sr_q  <= a_sr_q >> 1;
      b_sr_q  <= b_sr_q >> 1;
      s_sr_q  <= s_next;
      carry_q <= cell_co;
      if (last_bit) begin
        sum_q  <= s_next;
        cout_q <= cell_co;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results are pushed to a
// scoreboard queue at launch and popped when done is seen.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W:0]   exp_q[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one accepted start and record the expected {cout, sum}.
  task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                        input logic ss);
    logic [W:0] r;
    if (ss) begin
      r = {1'b0, aa} - {1'b0, bb};
      exp_q.push_back({~r[W], r[W-1:0]});
    end else begin
      exp_q.push_back({1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc});
    end
    a   = aa;
    b   = bb;
    cin = cc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ss;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, check busy meanwhile, the latency, and the scoreboard head.
  task automatic wait_done(input string tag, input int exp_cycles);
    int         waited;
    logic [W:0] e;
    waited = 0;
    while (done !== 1'b1 && waited < 3 * W) begin
      check({tag, "_busy"}, busy, 1);
      step();
      waited++;
    end
    check({tag, "_latency"}, waited, exp_cycles);
    check({tag, "_done"}, done, 1);
    n_checks++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, sum, e[W-1:0]);
      check({tag, "_cout"}, cout, e[W]);
    end
  endtask

  initial begin
    int pulses;
    int busy_seen;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif

    // Reset state
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // 0 + 0: busy 8 cycles, done in cycle 9
    launch(8'h00, 8'h00, 1'b0, 1'b0);
    wait_done("zero", W);
    step();
    check("zero_done_pulse", done, 0);
    check("zero_idle", busy, 0);

    // 0xFF + 0x01 wraps with carry; result held afterwards
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("wrap", W);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wrap_hold_sum", sum, 8'h00);
      check("wrap_hold_cout", cout, 1);
      check("wrap_hold_done", done, 0);
    end

    // 0xA5 + 0x5A + 1, then back-to-back start during done
    launch(8'hA5, 8'h5A, 1'b1, 1'b0);
    wait_done("a5", W);
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    check("b2b_no_gap", busy, 1);
    wait_done("b2b", W);

    // start pulses during RUN are ignored, operand changes have no effect
    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    step();
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a     = 8'h77;
    b     = 8'h88;
    start = 1'b1;
    cin   = 1'b1;
    step();
    start = 1'b0;
    wait_done("ignore", 3);
    pulses    = 0;
    busy_seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    check("ignore_single_done", pulses, 0);
    check("ignore_not_queued", busy_seen, 0);
    check("ignore_hold_sum", sum, 8'h10);

    // Reset mid-run at cnt=3 aborts without a done pulse
    launch(8'h33, 8'h44, 1'b0, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    pulses    = 0;
    busy_seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_idle", busy_seen, 0);

    // A few random additions
    for (int i = 0; i < 4; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      wait_done("rand", W);
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: 5 - 7 borrows, 7 - 5 does not
    launch(8'h05, 8'h07, 1'b1, 1'b1);
    wait_done("sub_borrow", W);
    check("sub_borrow_val", sum, 8'hFE);
    launch(8'h07, 8'h05, 1'b0, 1'b1);
    wait_done("sub_ok", W);
    check("sub_ok_val", sum, 8'h02);
    check("sub_ok_cout", cout, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
